// File: rtl/axa_undo_ctrl.sv
// Undo-stack controller and direction sequencer for the AXA pipeline.
// Owns the circular undo stack and the forward/reverse execution flag.
module axa_undo_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_req,
  input  logic [W-1:0]          push_data,
  output logic                  push_ack,
  input  logic                  pop_req,
  output logic                  pop_valid,
  output logic [W-1:0]          pop_data,
  input  logic [DEPTH_LOG2-1:0] peek_off,
  output logic [W-1:0]          peek_data,
  output logic                  peek_bad,
  input  logic                  flip_req,
  input  logic                  pipe_idle,
  output logic                  fwd,
  output logic                  stall,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_FWD     = 2'd0,
    S_DRAIN_R = 2'd1,
    S_REV     = 2'd2,
    S_DRAIN_F = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   sp;
  logic [PW-1:0]   sp_m1;
  logic [PW-1:0]   peek_idx;
  logic [W-1:0]    mem [DEPTH];
  logic            pop_fire;

  // Direction state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FWD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and direction decode; drains only exit once the pipe is idle
  always_comb begin
    state_nxt = state;
    fwd       = 1'b1;
    stall     = 1'b0;
    push_ack  = 1'b0;
    pop_fire  = 1'b0;
    case (state)
      S_FWD: begin
        push_ack = push_req;
        if (flip_req) begin
          state_nxt = S_DRAIN_R;
        end
      end
      S_DRAIN_R: begin
        stall = 1'b1;
        if (pipe_idle) begin
          state_nxt = S_REV;
        end
      end
      S_REV: begin
        fwd      = 1'b0;
        pop_fire = pop_req;
        if (flip_req) begin
          state_nxt = S_DRAIN_F;
        end
      end
      S_DRAIN_F: begin
        fwd   = 1'b0;
        stall = 1'b1;
        if (pipe_idle) begin
          state_nxt = S_FWD;
        end
      end
      default: begin
        state_nxt = S_FWD;
      end
    endcase
  end

  assign sp_m1    = sp - PW'(1);
  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(DEPTH));
  assign peek_idx = sp - peek_off - PW'(1);
  assign peek_data = mem[peek_idx];
  assign peek_bad  = ({1'b0, peek_off} >= count);

  // Stack pointer, occupancy and pop result; a full push overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      if (push_ack) begin
        sp <= sp + PW'(1);
        if (!full) begin
          count <= count + CW'(1);
        end
      end else if (pop_fire) begin
        pop_valid <= 1'b1;
        if (empty) begin
          pop_data  <= '0;
          underflow <= 1'b1;
        end else begin
          sp       <= sp_m1;
          count    <= count - CW'(1);
          pop_data <= mem[sp_m1];
        end
      end
    end
  end

  // Stack storage is deliberately left uninitialised by reset
  always_ff @(posedge clk) begin
    if (push_ack && !reset) begin
      mem[sp] <= push_data;
    end
  end

endmodule

// File: tb/tb_axa_undo_ctrl.sv
// Directed bench for axa_undo_ctrl: push/peek, flip/drain, pop order,
// underflow, overflow overwrite, wrap-around, gating and reset mid-drain.
module tb_axa_undo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_req;
  logic [15:0] push_data;
  logic        push_ack;
  logic        pop_req;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic [3:0]  peek_off;
  logic [15:0] peek_data;
  logic        peek_bad;
  logic        flip_req;
  logic        pipe_idle;
  logic        fwd;
  logic        stall;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  axa_undo_ctrl #(.DEPTH_LOG2(4), .W(16)) dut (
    .clk(clk), .reset(reset),
    .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .peek_off(peek_off), .peek_data(peek_data), .peek_bad(peek_bad),
    .flip_req(flip_req), .pipe_idle(pipe_idle),
    .fwd(fwd), .stall(stall), .count(count),
    .empty(empty), .full(full), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; push_req = 1'b0; push_data = '0; pop_req = 1'b0;
    peek_off = '0; flip_req = 1'b0; pipe_idle = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_fwd", 32'(fwd), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_uflow", 32'(underflow), 32'd0);
    check("rst_pvalid", 32'(pop_valid), 32'd0);
    check("rst_pdata", 32'(pop_data), 32'd0);

    // Three pushes in FWD
    push_req = 1'b1;
    push_data = 16'h1111; #1; check("push_ack0", 32'(push_ack), 32'd1); step();
    push_data = 16'h2222; #1; check("push_ack1", 32'(push_ack), 32'd1); step();
    push_data = 16'h3333; #1; check("push_ack2", 32'(push_ack), 32'd1); step();
    push_req = 1'b0;
    peek_off = 4'd0; #1; check("peek0", 32'(peek_data), 32'h3333);
    peek_off = 4'd2; #1; check("peek2", 32'(peek_data), 32'h1111);
    check("peek2_bad", 32'(peek_bad), 32'd0);
    peek_off = 4'd3; #1; check("peek3_bad", 32'(peek_bad), 32'd1);
    check("count3", 32'(count), 32'd3);

    // Pop in FWD is ignored
    pop_req = 1'b1; step();
    check("fwd_pop_valid", 32'(pop_valid), 32'd0);
    check("fwd_pop_count", 32'(count), 32'd3);
    pop_req = 1'b0;

    // Flip to reverse with a slow drain; a repeat flip in DRAIN_R is ignored
    flip_req = 1'b1; pipe_idle = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      flip_req = (i == 0);
      push_req = 1'b1; push_data = 16'hdead; #1;
      check("drain_r_ack", 32'(push_ack), 32'd0);
      check("drain_r_stall", 32'(stall), 32'd1);
      check("drain_r_fwd", 32'(fwd), 32'd1);
      step();
    end
    flip_req = 1'b0; push_req = 1'b0;
    check("drain_r_count", 32'(count), 32'd3);
    pipe_idle = 1'b1; step(); pipe_idle = 1'b0;
    check("rev_fwd", 32'(fwd), 32'd0);
    check("rev_stall", 32'(stall), 32'd0);

    // Push in REV is dropped
    push_req = 1'b1; push_data = 16'hbeef; #1;
    check("rev_push_ack", 32'(push_ack), 32'd0);
    step(); push_req = 1'b0;
    check("rev_push_count", 32'(count), 32'd3);
    peek_off = 4'd0; #1; check("rev_peek0", 32'(peek_data), 32'h3333);

    // Back-to-back pops then one underflow pop
    pop_req = 1'b1;
    step(); check("pop1_v", 32'(pop_valid), 32'd1); check("pop1_d", 32'(pop_data), 32'h3333);
    check("pop1_cnt", 32'(count), 32'd2);
    step(); check("pop2_v", 32'(pop_valid), 32'd1); check("pop2_d", 32'(pop_data), 32'h2222);
    step(); check("pop3_v", 32'(pop_valid), 32'd1); check("pop3_d", 32'(pop_data), 32'h1111);
    check("pop3_empty", 32'(empty), 32'd1);
    check("pop3_uflow", 32'(underflow), 32'd0);
    step(); check("pop4_v", 32'(pop_valid), 32'd1); check("pop4_d", 32'(pop_data), 32'h0);
    check("pop4_uflow", 32'(underflow), 32'd1);
    check("pop4_cnt", 32'(count), 32'd0);
    pop_req = 1'b0;
    step(); check("pop_idle_v", 32'(pop_valid), 32'd0);
    check("uflow_sticky", 32'(underflow), 32'd1);
    check("one_flip", 32'(fwd), 32'd0);

    // flip_req with pipe_idle in REV must go through DRAIN_F
    flip_req = 1'b1; pipe_idle = 1'b1; step(); flip_req = 1'b0;
    check("drain_f_stall", 32'(stall), 32'd1);
    check("drain_f_fwd", 32'(fwd), 32'd0);
    step(); pipe_idle = 1'b0;
    check("back_fwd", 32'(fwd), 32'd1);
    check("back_stall", 32'(stall), 32'd0);

    // 18 pushes overwrite the two oldest entries
    push_req = 1'b1;
    for (int i = 0; i < 18; i++) begin
      push_data = 16'(i); step();
    end
    push_req = 1'b0;
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_full", 32'(full), 32'd1);
    peek_off = 4'd15; #1; check("ovf_peek15", 32'(peek_data), 32'h0002);
    check("ovf_peek15_bad", 32'(peek_bad), 32'd0);
    peek_off = 4'd0; #1; check("ovf_peek0", 32'(peek_data), 32'h0011);

    // Reverse again and pop across the 0 -> 15 pointer wrap
    flip_req = 1'b1; step(); flip_req = 1'b0;
    pipe_idle = 1'b1; step(); pipe_idle = 1'b0;
    pop_req = 1'b1;
    step(); check("wrap_pop1", 32'(pop_data), 32'h0011);
    step(); check("wrap_pop2", 32'(pop_data), 32'h0010);
    step(); check("wrap_pop3", 32'(pop_data), 32'h000f);
    pop_req = 1'b0;
    check("wrap_count", 32'(count), 32'd13);
    check("wrap_full", 32'(full), 32'd0);

    // Reset while in DRAIN_F with a pop request pending
    flip_req = 1'b1; step(); flip_req = 1'b0;
    check("mid_drain_stall", 32'(stall), 32'd1);
    reset = 1'b1; pop_req = 1'b1; step();
    reset = 1'b0; pop_req = 1'b0;
    check("mid_rst_fwd", 32'(fwd), 32'd1);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_pvalid", 32'(pop_valid), 32'd0);
    check("mid_rst_uflow", 32'(underflow), 32'd0);
    push_req = 1'b1; push_data = 16'h4444; #1;
    check("post_rst_ack", 32'(push_ack), 32'd1);
    step(); push_req = 1'b0;
    check("post_rst_count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
